// File: rtl/elevator_request_queue.sv
// rtl/elevator_request_queue.sv - pending floor-call bitmap with SCAN-style direction recommendation
//
// Holds the floor calls that are still pending and tells the car which way to go next.
//
// Ports:
//   clk              system clock, all logic on the rising edge
//   reset            synchronous active-low reset
//   floor_req_valid  one-cycle request strobe
//   floor_req        requested floor, sampled with floor_req_valid
//   current_floor    car position
//   current_up_ndown car direction; monitored only
//   deassert_floor   disembark level from the car; only its rising edge clears a call
//   queue_status     pending-floor bitmap, bit i = floor i
//   queue_empty      queue_status == 0
//   next_up_ndown    recommended next direction, 1 = up, 0 = down
//   req_ack          one-cycle pulse, request accepted
//   req_err          one-cycle pulse, request rejected (floor out of range)
module elevator_request_queue #(
    parameter int NUM_FLOORS = 7,
    parameter int FLOOR_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  floor_req_valid,
    input  logic [FLOOR_W-1:0]    floor_req,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  current_up_ndown,
    input  logic                  deassert_floor,
    output logic [NUM_FLOORS-1:0] queue_status,
    output logic                  queue_empty,
    output logic                  next_up_ndown,
    output logic                  req_ack,
    output logic                  req_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    // One extra bit so NUM_FLOORS == 2**FLOOR_W still compares correctly.
    localparam logic [FLOOR_W:0] NUM_FLOORS_W = NUM_FLOORS[FLOOR_W:0];
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

    logic                  deassert_q;
    logic                  clr_ev;
    logic                  req_in_range;
    logic                  set_ok;
    logic [NUM_FLOORS-1:0] set_mask;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic [NUM_FLOORS-1:0] status_d;
    logic                  above;
    logic                  below;
    state_t                state_q;
    state_t                state_d;
    logic                  dir_d;

    // The car's own direction has no bearing on the decision; kept as a port for monitoring.
    logic unused_current_up_ndown;
    assign unused_current_up_ndown = current_up_ndown;

    assign clr_ev       = deassert_floor & ~deassert_q;
    assign req_in_range = ({1'b0, floor_req} < NUM_FLOORS_W);
    assign set_ok       = floor_req_valid & req_in_range;

    // An out-of-range current_floor matches no bit, so nothing is cleared for it.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        above    = 1'b0;
        below    = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            set_mask[i] = set_ok & (floor_req == FLOOR_W'(i));
            clr_mask[i] = clr_ev & (current_floor == FLOOR_W'(i));
            if (queue_status[i] && (FLOOR_W'(i) > current_floor)) above = 1'b1;
            if (queue_status[i] && (FLOOR_W'(i) < current_floor)) below = 1'b1;
        end
    end

    // Clear is applied after set: a passenger served at a floor cancels a same-cycle call there.
    assign status_d = (queue_status | set_mask) & ~clr_mask;

    always_ff @(posedge clk) begin
        if (!reset) begin
            queue_status <= '0;
            queue_empty  <= 1'b1;
            req_ack      <= 1'b0;
            req_err      <= 1'b0;
            deassert_q   <= 1'b0;
        end else begin
            queue_status <= status_d;
            queue_empty  <= (status_d == '0);
            req_ack      <= set_ok;
            req_err      <= floor_req_valid & ~req_in_range;
            deassert_q   <= deassert_floor;
        end
    end

    // Direction FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            next_up_ndown <= 1'b1;
        end else begin
            state_q       <= state_d;
            next_up_ndown <= dir_d;
        end
    end

    // Direction FSM: next state; keeps sweeping the current way while calls remain ahead
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = above ? ST_UP   : (below ? ST_DOWN : ST_IDLE);
            ST_UP:   state_d = above ? ST_UP   : (below ? ST_DOWN : ST_IDLE);
            ST_DOWN: state_d = below ? ST_DOWN : (above ? ST_UP   : ST_IDLE);
            default: state_d = ST_IDLE;
        endcase
    end

    // Direction FSM: output, registered alongside the state
    always_comb begin
        dir_d = 1'b1;
        case (state_d)
            ST_UP:   dir_d = 1'b1;
            ST_DOWN: dir_d = 1'b0;
            default: dir_d = (current_floor != TOP_FLOOR);
        endcase
    end

endmodule
